cache_fill_arbiter: RTL
=======================

# cache_fill_arbiter

Arbiter and sequencer that shares the single pipelined main memory between the I-cache miss path (fetch side) and the D-cache miss/store path (memory stage). It grants one requester at a time and runs either an 8-word block fill (read burst) or a single-word write-through store. It returns fill words tagged with their word index, and pulses a per-requester done. While a requester waits, the pipeline stall sources (fetch and memory-stage stall) are driven from its outputs.

## Interface
Parameters:
- ADDR_W, 16, byte address width
- DATA_W, 16, word width
- MEM_LAT, 4, cycles from mem_en issue to mem_rvalid; range 1..7
- BLK_WORDS, 8, words per cache block; power of two

Ports:
- clk  in  1  system clock, all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- i_req  in  1  I-cache miss request; level, held until i_done
- i_addr  in  ADDR_W  I-side miss address; low log2(BLK_WORDS)+1 bits ignored
- d_req  in  1  D-side request; level, held until d_done
- d_wr  in  1  D-side op: 1 = single-word store, 0 = block fill
- d_addr  in  ADDR_W  D-side address (word-aligned for stores)
- d_wdata  in  DATA_W  store data
- mem_en  out  1  memory access strobe, one access per cycle
- mem_wr  out  1  write qualifier for mem_en
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_rvalid  in  1  read data valid, MEM_LAT cycles after a read issue
- mem_rdata  in  DATA_W  read data
- fill_data  out  DATA_W  registered copy of mem_rdata
- i_fill_we  out  1  fill_data valid for the I-cache
- d_fill_we  out  1  fill_data valid for the D-cache
- fill_idx  out  log2(BLK_WORDS)  word index of fill_data within the block
- i_done, d_done  out  1  one-cycle completion pulses
- i_stall, d_stall  out  1  req held and not yet done (combinational)

## Operation
- FSM states: IDLE, FILL_ISSUE, FILL_WAIT, STORE.
- IDLE: evaluate requests. With a grant, latch the owner, block base and op, then go to FILL_ISSUE (fill) or STORE (d_wr=1).
- FILL_ISSUE: issue BLK_WORDS reads on consecutive cycles.
  - mem_addr = {base, issue_cnt, 1'b0}.
  - After the last issue, go to FILL_WAIT.
- Return counter: counts mem_rvalid in FILL_ISSUE and FILL_WAIT, independent of the issue counter.
  - Each return registers fill_data and fill_idx = return count, and asserts the owner's fill_we.
- Last return: pulse the owner's done on the cycle its fill_we asserts, then return to IDLE.
- STORE: one cycle with mem_en=mem_wr=1, address d_addr, data d_wdata. d_done is pulsed in the same cycle, then the FSM returns to IDLE.
- Request deassert mid-operation: ignored; the operation completes and done still pulses.
- mem_rvalid in IDLE or STORE: ignored, no fill_we.
- Counters are log2(BLK_WORDS) bits and wrap naturally. Reaching the terminal count, not wrap, ends each phase.
- Reset (any state, including mid-burst): FSM to IDLE, counters cleared. Any owed returns still in flight are dropped.
- Reset values: every output is 0, except i_stall and d_stall, which follow the request inputs.

## Timing
- Grant decision is combinational in IDLE; the grant is registered. Let G be the first cycle in FILL_ISSUE or STORE.
- Fill: mem_en at G..G+BLK_WORDS-1.
  - mem_rvalid at G+MEM_LAT..G+MEM_LAT+BLK_WORDS-1.
  - fill_we one cycle later, from the registered data.
  - done on the last fill_we. Default parameters: done at G+12, IDLE at G+13.
- Store: done at G, IDLE at G+1.
- Back-to-back: a request pending in IDLE is granted that cycle, so the next G = IDLE cycle + 1.

## Configuration
- CACHE_ARB_RR_EN defined: round-robin arbitration. On simultaneous i_req and d_req, the requester not granted last wins. Last-grant flop resets to I, so D wins the first tie.
- Not defined: fixed priority, D-side always wins ties. No last-grant flop.

## Structure
- Shared package: FSM state enum, owner encoding (OWN_I, OWN_D), BLK_WORDS/MEM_LAT defaults, and the index-width constant.
- Sub-module arb_pick: combinational picker of req pair plus last-grant to a one-hot grant. It contains the CACHE_ARB_RR_EN variation.

## Test plan
- I fill alone: i_req=1, i_addr=0x1234. Required: mem_addr 0x1230,0x1232..0x123E at G..G+7. fill_idx 0..7 on i_fill_we at G+5..G+12. i_done at G+12. i_stall low from G+13.
- Store alone: d_req=1, d_wr=1, d_addr=0x0040, d_wdata=0xBEEF. Required: one mem_en+mem_wr cycle with those values, d_done the same cycle, no fill_we.
- Simultaneous I fill and D fill: fixed build serves D then I. RR build serves D first; with repeated ties, grants alternate D, I, D.
- Request dropped mid-fill: i_req low at G+3. Required: burst still issues 8 reads and 8 fill_we, and i_done pulses.
- Reset at G+6 of a fill: all outputs 0 immediately. Later mem_rvalid pulses produce no fill_we. A new request gets a fresh 8-word burst.
- Stray mem_rvalid in IDLE with no requests: no fill_we, FSM stays IDLE.

Source files
------------

// File: rtl/cache_fill_arbiter_pkg.sv
// cache_fill_arbiter_pkg: shared states, owner encoding and default sizes for cache_fill_arbiter
package cache_fill_arbiter_pkg;
  localparam int BLK_WORDS_DEF = 8;
  localparam int MEM_LAT_DEF = 4;
  localparam int IDX_W_DEF = $clog2(BLK_WORDS_DEF);
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_FILL_ISSUE = 2'd1;
  localparam logic [1:0] S_FILL_WAIT = 2'd2;
  localparam logic [1:0] S_STORE = 2'd3;
  typedef enum logic {OWN_I = 1'b0, OWN_D = 1'b1} owner_t;
endpackage

// File: rtl/cache_fill_arbiter_arb_pick.sv
// arb_pick: one-hot grant {d, i} from the request pair; CACHE_ARB_RR_EN selects round-robin ties
module arb_pick
  import cache_fill_arbiter_pkg::*;
(
  input  logic       i_req,
  input  logic       d_req,
`ifdef CACHE_ARB_RR_EN
  input  owner_t     last,
`endif
  output logic [1:0] grant
);
  logic d_win;
  // D wins when alone, or on a tie when it is D's turn (always D in the fixed build)
  always_comb begin
`ifdef CACHE_ARB_RR_EN
    d_win = d_req && (!i_req || last == OWN_I);
`else
    d_win = d_req;
`endif
    grant = {d_win, i_req && !d_win};
  end
endmodule

// File: rtl/cache_fill_arbiter.sv
// cache_fill_arbiter: shares one pipelined memory between I-cache fills and D-cache fills/stores
// Build option: define CACHE_ARB_RR_EN for round-robin tie-breaking (default: D-side wins ties)
module cache_fill_arbiter
  import cache_fill_arbiter_pkg::*;
#(
  parameter int ADDR_W    = 16,
  parameter int DATA_W    = 16,
  parameter int MEM_LAT   = MEM_LAT_DEF,
  parameter int BLK_WORDS = BLK_WORDS_DEF
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         i_req,
  input  logic [ADDR_W-1:0]            i_addr,
  input  logic                         d_req,
  input  logic                         d_wr,
  input  logic [ADDR_W-1:0]            d_addr,
  input  logic [DATA_W-1:0]            d_wdata,
  output logic                         mem_en,
  output logic                         mem_wr,
  output logic [ADDR_W-1:0]            mem_addr,
  output logic [DATA_W-1:0]            mem_wdata,
  input  logic                         mem_rvalid,
  input  logic [DATA_W-1:0]            mem_rdata,
  output logic [DATA_W-1:0]            fill_data,
  output logic                         i_fill_we,
  output logic                         d_fill_we,
  output logic [$clog2(BLK_WORDS)-1:0] fill_idx,
  output logic                         i_done,
  output logic                         d_done,
  output logic                         i_stall,
  output logic                         d_stall
);
  localparam int IW = $clog2(BLK_WORDS);
  localparam int BW = ADDR_W - IW - 1;
  localparam logic [IW-1:0] LAST = IW'(BLK_WORDS - 1);
  localparam int lat_unused = MEM_LAT;
  logic [1:0] state;
  owner_t owner;
  logic [BW-1:0] base;
  logic [IW-1:0] issue_cnt, ret_cnt;
  logic i_done_q, d_done_q, ret_ok, last_ret;
  logic [1:0] grant;
  logic unused;
  assign unused = ^i_addr[IW:0];
  arb_pick u_pick (
    .i_req(i_req),
    .d_req(d_req),
`ifdef CACHE_ARB_RR_EN
    .last(owner),
`endif
    .grant(grant)
  );
  // sequencer: grant in IDLE, issue the burst, wait for the final return, or do a one-cycle store
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= S_IDLE;
      owner <= OWN_I;
      base <= '0;
      issue_cnt <= '0;
    end else if (state == S_IDLE) begin
      if (|grant) begin
        owner <= grant[1] ? OWN_D : OWN_I;
        base <= grant[1] ? d_addr[ADDR_W-1:IW+1] : i_addr[ADDR_W-1:IW+1];
        issue_cnt <= '0;
        state <= grant[1] && d_wr ? S_STORE : S_FILL_ISSUE;
      end
    end else if (state == S_FILL_ISSUE) begin
      issue_cnt <= issue_cnt + 1'b1;
      if (issue_cnt == LAST) state <= S_FILL_WAIT;
    end else if (state == S_FILL_WAIT) begin
      if (i_done_q || d_done_q) state <= S_IDLE;
    end else begin
      state <= S_IDLE;
    end
  // a return counts only while a fill is open and before its done pulse has been raised
  always_comb begin
    ret_ok = mem_rvalid && (state == S_FILL_ISSUE || state == S_FILL_WAIT) && !(i_done_q || d_done_q);
    last_ret = ret_ok && ret_cnt == LAST;
  end
  // return path: register data and index, steer the write enable and done to the owner
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      ret_cnt <= '0;
      fill_data <= '0;
      fill_idx <= '0;
      i_fill_we <= 1'b0;
      d_fill_we <= 1'b0;
      i_done_q <= 1'b0;
      d_done_q <= 1'b0;
    end else begin
      ret_cnt <= state == S_IDLE ? '0 : ret_cnt + IW'(ret_ok);
      fill_data <= ret_ok ? mem_rdata : fill_data;
      fill_idx <= ret_ok ? ret_cnt : fill_idx;
      i_fill_we <= ret_ok && owner == OWN_I;
      d_fill_we <= ret_ok && owner == OWN_D;
      i_done_q <= last_ret && owner == OWN_I;
      d_done_q <= last_ret && owner == OWN_D;
    end
  // memory strobes follow the state; a store completes in its own cycle
  always_comb begin
    mem_en = state == S_FILL_ISSUE || state == S_STORE;
    mem_wr = state == S_STORE;
    mem_addr = state == S_FILL_ISSUE ? {base, issue_cnt, 1'b0} : mem_wr ? d_addr : '0;
    mem_wdata = mem_wr ? d_wdata : '0;
    i_done = i_done_q;
    d_done = d_done_q || mem_wr;
    i_stall = i_req && !i_done;
    d_stall = d_req && !d_done;
  end
endmodule
